// File: rtl/sprite_pkg.sv
// Purpose: shared screen geometry and scheduler state encoding for the sprite blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sprite_pkg;

   localparam int H_RES      = 640;
   localparam int V_RES      = 480;
   localparam int V_RES_FULL = 525;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      UPDATE = 1'b1
   } state_t;

endpackage

// File: rtl/sprite_bounce.sv
// Purpose: one-axis motion step with bounce at the low edge (0) and the high limit.
// Latency: purely combinational.
// Backpressure: none; evaluated whenever the caller samples it.
module sprite_bounce #(
   parameter int CORDW = 10
) (
   input  logic [CORDW-1:0] pos,
   input  logic             dir,
   input  logic [CORDW-1:0] limit,
   input  logic [CORDW-1:0] speed,
   output logic [CORDW-1:0] pos_next,
   output logic             dir_next
);

   // Move one step; reverse when the step would cross the limit or go below zero.
   always_comb begin
      dir_next = dir;
      pos_next = dir ? (pos - speed) : (pos + speed);
      if (!dir && (pos >= limit)) begin
         dir_next = 1'b1;
         pos_next = pos - speed;
      end else if (dir && (pos < speed)) begin
         dir_next = 1'b0;
         pos_next = pos + speed;
      end
   end

endmodule

// File: rtl/sprite_sched.sv
// Purpose: per-sprite position store, once-per-frame bounce update, line-start pulses, pixel arbitration.
// Latency: update runs NSPR cycles from the frame trigger; start/pixel outputs are combinational.
// Backpressure: cfg_ready drops during the update (and in the trigger cycle); a held write waits.
module sprite_sched #(
   parameter int NSPR       = 4,
   parameter int CORDW      = 10,
   parameter int H_RES      = sprite_pkg::H_RES,
   parameter int V_RES      = sprite_pkg::V_RES,
   parameter int V_RES_FULL = sprite_pkg::V_RES_FULL,
   parameter int SPR_W      = 48,
   parameter int SPR_H      = 48,
   parameter int SPEED_X    = 4,
   parameter int SPEED_Y    = 2
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [CORDW-1:0]                          sx,
   input  logic [CORDW-1:0]                          sy,
   input  logic                                      cfg_valid,
   output logic                                      cfg_ready,
   input  logic [((NSPR > 1) ? $clog2(NSPR) : 1)-1:0] cfg_id,
   input  logic [CORDW-1:0]                          cfg_x,
   input  logic [CORDW-1:0]                          cfg_y,
   input  logic                                      cfg_dx,
   input  logic                                      cfg_dy,
   input  logic                                      cfg_en,
   output logic [NSPR-1:0]                           spr_start,
   output logic [NSPR*CORDW-1:0]                     sprx,
   input  logic [NSPR-1:0]                           spr_pix_in,
   output logic                                      pix,
   output logic [((NSPR > 1) ? $clog2(NSPR) : 1)-1:0] pix_id,
   output logic                                      busy
);

   import sprite_pkg::*;

   localparam int IDW = (NSPR > 1) ? $clog2(NSPR) : 1;

   localparam logic [CORDW-1:0] X_LIM  = CORDW'(H_RES - SPEED_X - SPR_W);
   localparam logic [CORDW-1:0] Y_LIM  = CORDW'(V_RES - SPEED_Y - SPR_H);
   localparam logic [CORDW-1:0] X_SPD  = CORDW'(SPEED_X);
   localparam logic [CORDW-1:0] Y_SPD  = CORDW'(SPEED_Y);
   localparam logic [CORDW-1:0] X_RST  = CORDW'((H_RES - SPR_W) / 2);
   localparam logic [CORDW-1:0] Y_RST  = CORDW'((V_RES - SPR_H) / 2);
   localparam logic [CORDW-1:0] H_END  = CORDW'(H_RES);
   localparam logic [CORDW-1:0] V_TRIG = CORDW'(V_RES);
   localparam logic [CORDW-1:0] V_LAST = CORDW'(V_RES_FULL - 1);
   localparam logic [IDW-1:0]   IDX_LAST = IDW'(NSPR - 1);

   state_t             state_q, state_d;
   logic [IDW-1:0]     idx_q;
   logic [CORDW-1:0]   x_q [NSPR];
   logic [CORDW-1:0]   y_q [NSPR];
   logic [NSPR-1:0]    dx_q, dy_q, en_q;
   logic               trigger, upd_last, cfg_fire;
   logic [CORDW-1:0]   x_nxt, y_nxt;
   logic               dx_nxt, dy_nxt;
   logic [NSPR-1:0]    pix_hits;

   // Frame trigger: first pixel of the first blanking line, only while idle.
   assign trigger  = rst_n && (state_q == IDLE) && (sy == V_TRIG) && (sx == '0);
   assign upd_last = (idx_q == IDX_LAST);
   assign cfg_fire = cfg_valid && cfg_ready && (int'(cfg_id) < NSPR);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and handshake outputs; the trigger wins over a config write.
   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      cfg_ready = 1'b0;
      case (state_q)
         IDLE: begin
            cfg_ready = !trigger;
            if (trigger) state_d = UPDATE;
         end
         UPDATE: begin
            busy = 1'b1;
            if (upd_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Sprite index walked once per update pass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 idx_q <= '0;
      else if (state_q == UPDATE) idx_q <= upd_last ? '0 : idx_q + 1'b1;
   end

   sprite_bounce #(.CORDW(CORDW)) u_bounce_x (
      .pos(x_q[idx_q]), .dir(dx_q[idx_q]), .limit(X_LIM), .speed(X_SPD),
      .pos_next(x_nxt), .dir_next(dx_nxt)
   );

   sprite_bounce #(.CORDW(CORDW)) u_bounce_y (
      .pos(y_q[idx_q]), .dir(dy_q[idx_q]), .limit(Y_LIM), .speed(Y_SPD),
      .pos_next(y_nxt), .dir_next(dy_nxt)
   );

   // Sprite state: config writes when idle, bounce step for the indexed enabled sprite.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NSPR; i++) begin
            x_q[i]  <= X_RST;
            y_q[i]  <= Y_RST;
            dx_q[i] <= 1'b0;
            dy_q[i] <= 1'b0;
            en_q[i] <= (i == 0);
         end
      end else if (cfg_fire) begin
         x_q[cfg_id]  <= cfg_x;
         y_q[cfg_id]  <= cfg_y;
         dx_q[cfg_id] <= cfg_dx;
         dy_q[cfg_id] <= cfg_dy;
         en_q[cfg_id] <= cfg_en;
      end else if ((state_q == UPDATE) && en_q[idx_q]) begin
         x_q[idx_q]  <= x_nxt;
         y_q[idx_q]  <= y_nxt;
         dx_q[idx_q] <= dx_nxt;
         dy_q[idx_q] <= dy_nxt;
      end
   end

   // Line-start pulse one line ahead of each sprite's top row, wrapping at line 0.
   always_comb begin
      spr_start = '0;
      for (int i = 0; i < NSPR; i++) begin
         spr_start[i] = en_q[i] && (sx == H_END) &&
                        (sy == ((y_q[i] == '0) ? V_LAST : (y_q[i] - 1'b1)));
      end
   end

   // Packed X positions for the engines.
   always_comb begin
      sprx = '0;
      for (int i = 0; i < NSPR; i++) sprx[i*CORDW +: CORDW] = x_q[i];
   end

   assign pix_hits = spr_pix_in & en_q;

   // Pixel arbitration: lowest enabled sprite with an opaque pixel wins.
   always_comb begin
      pix    = |pix_hits;
      pix_id = '0;
      for (int i = NSPR - 1; i >= 0; i--) begin
         if (pix_hits[i]) pix_id = IDW'(i);
      end
   end

endmodule

// File: tb/tb_sprite_sched.sv
// Purpose: self-checking bench for sprite_sched against a frame-level behavioural model.
// Latency: update results are scored when busy falls; combinational outputs checked in-cycle.
// Backpressure: config writes wait on cfg_ready with a bounded retry count.
module tb_sprite_sched;

   localparam int NSPR = 4, CORDW = 10;
   localparam int H_RES = 640, V_RES = 480, V_RES_FULL = 525;
   localparam int SPR_W = 48, SPR_H = 48, SPEED_X = 4, SPEED_Y = 2;

   logic                    clk, rst_n;
   logic [CORDW-1:0]        sx, sy;
   logic                    cfg_valid, cfg_ready;
   logic [1:0]              cfg_id;
   logic [CORDW-1:0]        cfg_x, cfg_y;
   logic                    cfg_dx, cfg_dy, cfg_en;
   logic [NSPR-1:0]         spr_start;
   logic [NSPR*CORDW-1:0]   sprx;
   logic [NSPR-1:0]         spr_pix_in;
   logic                    pix;
   logic [1:0]              pix_id;
   logic                    busy;

   sprite_sched #(
      .NSPR(NSPR), .CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES), .V_RES_FULL(V_RES_FULL),
      .SPR_W(SPR_W), .SPR_H(SPR_H), .SPEED_X(SPEED_X), .SPEED_Y(SPEED_Y)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sx(sx), .sy(sy),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_id(cfg_id),
      .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_dx(cfg_dx), .cfg_dy(cfg_dy), .cfg_en(cfg_en),
      .spr_start(spr_start), .sprx(sprx), .spr_pix_in(spr_pix_in),
      .pix(pix), .pix_id(pix_id), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state of every sprite, advanced a whole frame at a time.
   int m_x [NSPR];
   int m_y [NSPR];
   bit m_dx [NSPR];
   bit m_dy [NSPR];
   bit m_en [NSPR];

   int checks = 0;
   int errors = 0;
   logic [NSPR*CORDW-1:0] exp_q [$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NSPR; i++) begin
         m_x[i] = (H_RES - SPR_W) / 2;
         m_y[i] = (V_RES - SPR_H) / 2;
         m_dx[i] = 1'b0;
         m_dy[i] = 1'b0;
         m_en[i] = (i == 0);
      end
   endfunction

   // A sprite moving forward turns back once its far edge would reach the screen edge;
   // moving backward it turns once the step would take it below zero.
   function automatic void axis_step(input int p, input bit d, input int extent, input int spd,
                                     input int size, output int pn, output bit dn);
      if (!d) begin
         if (p + spd + size >= extent) begin dn = 1'b1; pn = p - spd; end
         else begin dn = 1'b0; pn = p + spd; end
      end else begin
         if (p - spd < 0) begin dn = 1'b0; pn = p + spd; end
         else begin dn = 1'b1; pn = p - spd; end
      end
   endfunction

   function automatic void model_frame();
      int  pn;
      bit  dn;
      for (int i = 0; i < NSPR; i++) begin
         if (m_en[i]) begin
            axis_step(m_x[i], m_dx[i], H_RES, SPEED_X, SPR_W, pn, dn);
            m_x[i] = pn; m_dx[i] = dn;
            axis_step(m_y[i], m_dy[i], V_RES, SPEED_Y, SPR_H, pn, dn);
            m_y[i] = pn; m_dy[i] = dn;
         end
      end
   endfunction

   function automatic logic [NSPR*CORDW-1:0] model_sprx();
      logic [NSPR*CORDW-1:0] r;
      r = '0;
      for (int i = 0; i < NSPR; i++) r[i*CORDW +: CORDW] = CORDW'(m_x[i]);
      return r;
   endfunction

   function automatic logic [NSPR-1:0] model_start(input int px, input int py);
      logic [NSPR-1:0] r;
      r = '0;
      for (int i = 0; i < NSPR; i++)
         r[i] = m_en[i] && (px == H_RES) && (py == (m_y[i] + V_RES_FULL - 1) % V_RES_FULL);
      return r;
   endfunction

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         #1;
         if (!busy) ok = 1'b1;
         else @(negedge clk);
      end
      if (!ok) chk("update_timeout", 64'd0, 64'd1);
      @(negedge clk);
   endtask

   task automatic cfg_write(input int id, input int x, input int y, input bit dx, input bit dy, input bit en);
      bit ok;
      ok = 1'b0;
      cfg_valid = 1'b1; cfg_id = 2'(id);
      cfg_x = CORDW'(x); cfg_y = CORDW'(y);
      cfg_dx = dx; cfg_dy = dy; cfg_en = en;
      for (int k = 0; k < 40 && !ok; k++) begin
         #1;
         if (cfg_ready) ok = 1'b1;
         @(posedge clk);
         if (ok) begin
            m_x[id] = x; m_y[id] = y; m_dx[id] = dx; m_dy[id] = dy; m_en[id] = en;
         end
         @(negedge clk);
      end
      cfg_valid = 1'b0;
      if (!ok) chk("cfg_ready_timeout", 64'd0, 64'd1);
   endtask

   task automatic frame();
      sx = '0; sy = CORDW'(V_RES);
      #1;
      chk("trigger_cfg_ready", 64'(cfg_ready), 64'd0);
      chk("trigger_busy", 64'(busy), 64'd0);
      model_frame();
      exp_q.push_back(model_sprx());
      @(negedge clk);
      sx = CORDW'(1); sy = '0;
      wait_idle();
   endtask

   task automatic probe_start(input int px, input int py);
      sx = CORDW'(px); sy = CORDW'(py);
      #1;
      chk("spr_start", 64'(spr_start), 64'(model_start(px, py)));
      @(negedge clk);
      sx = CORDW'(1); sy = '0;
   endtask

   task automatic probe_pix(input logic [NSPR-1:0] in);
      bit p;
      int id;
      spr_pix_in = in;
      #1;
      p = 1'b0; id = 0;
      for (int i = 0; i < NSPR; i++) begin
         if (in[i] && m_en[i] && !p) begin p = 1'b1; id = i; end
      end
      chk("pix", 64'(pix), 64'(p));
      chk("pix_id", 64'(pix_id), 64'(id));
      @(negedge clk);
      spr_pix_in = '0;
   endtask

   // Monitor: scores every completed update pass (length and resulting X positions).
   initial begin
      int   cnt;
      logic prev;
      logic [NSPR*CORDW-1:0] e;
      cnt = 0; prev = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            cnt = 0; prev = 1'b0;
         end else begin
            if (busy) cnt++;
            if (prev && !busy) begin
               chk("busy_cycles", 64'(cnt), 64'(NSPR));
               if (exp_q.size() == 0) chk("unexpected_update", 64'd1, 64'd0);
               else begin
                  e = exp_q.pop_front();
                  chk("sprx_after_update", 64'(sprx), 64'(e));
               end
               cnt = 0;
            end
            prev = busy;
         end
      end
   end

   initial begin
      rst_n = 1'b0; sx = CORDW'(1); sy = '0;
      cfg_valid = 1'b0; cfg_id = '0; cfg_x = '0; cfg_y = '0;
      cfg_dx = 1'b0; cfg_dy = 1'b0; cfg_en = 1'b0; spr_pix_in = '0;
      model_reset();

      // Reset state.
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
      chk("rst_pix", 64'(pix), 64'd0);
      chk("rst_pix_id", 64'(pix_id), 64'd0);
      chk("rst_sprx", 64'(sprx), 64'(model_sprx()));
      chk("rst_start_idle", 64'(spr_start), 64'd0);
      sx = CORDW'(640); sy = CORDW'(215);
      #1;
      chk("rst_start_spr0", 64'(spr_start), 64'd1);
      @(negedge clk);
      sx = CORDW'(1); sy = '0;
      rst_n = 1'b1;
      @(negedge clk);

      // Directed bounces and start-line wrap.
      cfg_write(1, 588, 100, 1'b0, 1'b0, 1'b1);
      cfg_write(2, 2, 1, 1'b1, 1'b1, 1'b1);
      cfg_write(3, 300, 0, 1'b0, 1'b0, 1'b1);
      probe_start(640, 524);
      probe_start(639, 524);
      probe_start(640, 523);
      probe_start(640, 215);
      probe_start(640, 99);
      frame();
      probe_start(640, 2);
      probe_start(640, 1);
      frame();
      probe_start(640, (m_y[2] + V_RES_FULL - 1) % V_RES_FULL);

      // Pixel priority.
      probe_pix(4'b0110);
      cfg_write(1, m_x[1], m_y[1], m_dx[1], m_dy[1], 1'b0);
      probe_pix(4'b0110);
      probe_pix(4'b0000);
      probe_pix(4'b1000);

      // Config write colliding with the frame trigger stays pending until the pass ends.
      sx = '0; sy = CORDW'(V_RES);
      cfg_valid = 1'b1; cfg_id = 2'd0; cfg_x = CORDW'(100); cfg_y = CORDW'(50);
      cfg_dx = 1'b1; cfg_dy = 1'b0; cfg_en = 1'b1;
      #1;
      chk("collide_cfg_ready", 64'(cfg_ready), 64'd0);
      model_frame();
      exp_q.push_back(model_sprx());
      @(negedge clk);
      sx = CORDW'(1); sy = '0;
      for (int k = 0; k < NSPR; k++) begin
         #1;
         chk("collide_busy", 64'(busy), 64'd1);
         chk("collide_hold", 64'(cfg_ready), 64'd0);
         @(negedge clk);
      end
      #1;
      chk("collide_ready_back", 64'(cfg_ready), 64'd1);
      @(posedge clk);
      m_x[0] = 100; m_y[0] = 50; m_dx[0] = 1'b1; m_dy[0] = 1'b0; m_en[0] = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      #1;
      chk("collide_write_landed", 64'(sprx), 64'(model_sprx()));
      @(negedge clk);
      probe_start(640, 49);

      // Reset in the middle of an update pass.
      sx = '0; sy = CORDW'(V_RES);
      @(negedge clk);
      sx = CORDW'(1); sy = '0;
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_cfg_ready", 64'(cfg_ready), 64'd1);
      chk("midrst_sprx", 64'(sprx), 64'(model_sprx()));
      sx = CORDW'(640); sy = CORDW'(215);
      #1;
      chk("midrst_start", 64'(spr_start), 64'd1);
      @(negedge clk);
      sx = CORDW'(1); sy = '0;
      rst_n = 1'b1;
      @(negedge clk);
      probe_pix(4'b1111);
      probe_pix(4'b1110);

      // Randomised frames.
      for (int f = 0; f < 12; f++) begin
         int n;
         n = $urandom_range(0, 3);
         for (int w = 0; w < n; w++) begin
            cfg_write($urandom_range(0, NSPR - 1), $urandom_range(0, 588), $urandom_range(0, 430),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
         frame();
         for (int i = 0; i < NSPR; i++) probe_start(640, (m_y[i] + V_RES_FULL - 1) % V_RES_FULL);
         probe_start(640, $urandom_range(0, V_RES_FULL - 1));
         probe_pix(4'($urandom_range(0, 15)));
      end

      // Drain the scoreboard.
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
